// File: rtl/branch_predict_ctrl.sv
// Branch target buffer with 2-bit history counters for the fetch stage.
// IF lookup is combinational. EX updates are written on the clock edge.
// A sweep FSM clears the valid bits after reset and after flush_req.
module branch_predict_ctrl #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    input  logic [31:0]      IF_pc,
    output logic             IF_BTBhit,
    output logic [1:0]       IF_branch_prediction,
    output logic [31:0]      IF_pc_imm,
    output logic             IF_Branch,
    output logic             IF_Jump,
    input  logic             EX_Branch,
    input  logic             EX_Jump,
    input  logic             EX_ALUSrc,
    input  logic [31:0]      EX_pc,
    input  logic [31:0]      EX_pc_imm,
    input  logic             EX_taken,
    input  logic [1:0]       EX_prediction,
    output logic [1:0]       prediction_status,
    output logic             init_done,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 32 - IDX_W - 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sweep_idx;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] is_branch_q;
    logic [ENTRIES-1:0] is_jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX_W-1:0]   if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [IDX_W-1:0]   ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic               run_upd;
    logic               do_br;
    logic               do_jal;
    logic               do_jalr_inv;
    logic [1:0]         new_cnt;
    logic               unused_pc_bits;

    assign if_idx = IF_pc[IDX_W+1:2];
    assign if_tag = IF_pc[31:IDX_W+2];
    assign ex_idx = EX_pc[IDX_W+1:2];
    assign ex_tag = EX_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{IF_pc[1:0], EX_pc[1:0]};

    assign init_done = (state == RUN);

    // IF lookup: forced miss while sweeping, otherwise valid and tag match
    always_comb begin
        IF_BTBhit            = 1'b0;
        IF_branch_prediction = 2'b00;
        IF_pc_imm            = 32'h0;
        IF_Branch            = 1'b0;
        IF_Jump              = 1'b0;
        if (state == RUN && valid[if_idx] && tag_q[if_idx] == if_tag) begin
            IF_BTBhit            = 1'b1;
            IF_branch_prediction = cnt_q[if_idx];
            IF_pc_imm            = target_q[if_idx];
            IF_Branch            = is_branch_q[if_idx];
            IF_Jump              = is_jump_q[if_idx];
        end
    end

    // Classify the resolved EX instruction against its carried prediction
    always_comb begin
        prediction_status = 2'd2;
        if (!EX_Branch) begin
            prediction_status = 2'd3;
        end else if (!EX_prediction[1] && EX_taken) begin
            prediction_status = 2'd0;
        end else if (EX_prediction[1] && !EX_taken) begin
            prediction_status = 2'd1;
        end
    end

    // Decode the EX update; flush drops it, branch wins over jump
    always_comb begin
        ex_hit      = valid[ex_idx] && (tag_q[ex_idx] == ex_tag);
        run_upd     = (state == RUN) && !flush_req;
        do_br       = run_upd && EX_Branch;
        do_jal      = run_upd && !EX_Branch && EX_Jump && !EX_ALUSrc;
        do_jalr_inv = run_upd && !EX_Branch && EX_Jump && EX_ALUSrc && ex_hit;
        new_cnt     = EX_taken ? 2'b10 : 2'b01;
        if (ex_hit) begin
            if (EX_taken) begin
                new_cnt = (cnt_q[ex_idx] == 2'b11) ? 2'b11 : cnt_q[ex_idx] + 2'd1;
            end else begin
                new_cnt = (cnt_q[ex_idx] == 2'b00) ? 2'b00 : cnt_q[ex_idx] - 2'd1;
            end
        end
    end

    // Sweep FSM: INIT clears one entry per cycle, RUN accepts updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (flush_req) begin
                        sweep_idx <= '0;
                    end else if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
                        state     <= RUN;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + IDX_W'(1);
                    end
                end
                RUN: begin
                    if (flush_req) begin
                        state     <= INIT;
                        sweep_idx <= '0;
                    end
                end
                default: begin
                    state     <= INIT;
                    sweep_idx <= '0;
                end
            endcase
        end
    end

    // Valid bits: swept clear in INIT, set on allocate, cleared by a hitting JALR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (state == INIT) begin
            valid[sweep_idx] <= 1'b0;
        end else if (do_br || do_jal) begin
            valid[ex_idx] <= 1'b1;
        end else if (do_jalr_inv) begin
            valid[ex_idx] <= 1'b0;
        end
    end

    // Entry payload; meaningful only while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (do_br) begin
            target_q[ex_idx] <= EX_pc_imm;
            cnt_q[ex_idx]    <= new_cnt;
            if (!ex_hit) begin
                tag_q[ex_idx]       <= ex_tag;
                is_branch_q[ex_idx] <= 1'b1;
                is_jump_q[ex_idx]   <= 1'b0;
            end
        end else if (do_jal) begin
            tag_q[ex_idx]       <= ex_tag;
            target_q[ex_idx]    <= EX_pc_imm;
            cnt_q[ex_idx]       <= 2'b11;
            is_branch_q[ex_idx] <= 1'b0;
            is_jump_q[ex_idx]   <= 1'b1;
        end
    end

    // Wrapping performance counters, kept across flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (state == RUN) begin
            if (EX_Branch) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (prediction_status == 2'd0 || prediction_status == 2'd1) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: sweep timing, lookup, counters, aliasing, flush.
module tb_branch_predict_ctrl;

    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 12;

    logic             clk;
    logic             rst_n;
    logic             flush_req;
    logic [31:0]      IF_pc;
    logic             IF_BTBhit;
    logic [1:0]       IF_branch_prediction;
    logic [31:0]      IF_pc_imm;
    logic             IF_Branch;
    logic             IF_Jump;
    logic             EX_Branch;
    logic             EX_Jump;
    logic             EX_ALUSrc;
    logic [31:0]      EX_pc;
    logic [31:0]      EX_pc_imm;
    logic             EX_taken;
    logic [1:0]       EX_prediction;
    logic [1:0]       prediction_status;
    logic             init_done;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    int compared   = 0;
    int mismatched = 0;

    branch_predict_ctrl #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_req           (flush_req),
        .IF_pc               (IF_pc),
        .IF_BTBhit           (IF_BTBhit),
        .IF_branch_prediction(IF_branch_prediction),
        .IF_pc_imm           (IF_pc_imm),
        .IF_Branch           (IF_Branch),
        .IF_Jump             (IF_Jump),
        .EX_Branch           (EX_Branch),
        .EX_Jump             (EX_Jump),
        .EX_ALUSrc           (EX_ALUSrc),
        .EX_pc               (EX_pc),
        .EX_pc_imm           (EX_pc_imm),
        .EX_taken            (EX_taken),
        .EX_prediction       (EX_prediction),
        .prediction_status   (prediction_status),
        .init_done           (init_done),
        .branch_cnt          (branch_cnt),
        .mispredict_cnt      (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ex_set(input logic br, input logic jmp, input logic src,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic tk, input logic [1:0] pr);
        EX_Branch     = br;
        EX_Jump       = jmp;
        EX_ALUSrc     = src;
        EX_pc         = pc;
        EX_pc_imm     = imm;
        EX_taken      = tk;
        EX_prediction = pr;
    endtask

    task automatic ex_idle();
        ex_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] pred_seq [9];
    logic       tk_seq   [9];
    logic [1:0] stat_exp [9];
    logic [1:0] cnt_exp  [9];
    logic       any_hit;

    initial begin
        pred_seq = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        tk_seq   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        stat_exp = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        cnt_exp  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};

        // Reset with IF_pc=0x40
        rst_n     = 1'b0;
        flush_req = 1'b0;
        IF_pc     = 32'h40;
        ex_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_hit", 32'(IF_BTBhit), 32'h0);
        check("rst_imm", IF_pc_imm, 32'h0);
        check("rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("rst_mispredict_cnt", 32'(mispredict_cnt), 32'h0);
        check("rst_status_nobranch", 32'(prediction_status), 32'd3);

        // Sweep after reset release lasts 64 cycles
        rst_n   = 1'b1;
        any_hit = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            any_hit = any_hit | IF_BTBhit;
            if (i == 63) check("sweep_63_not_done", 32'(init_done), 32'h0);
        end
        check("sweep_64_done", 32'(init_done), 32'h1);
        check("sweep_no_hit", 32'(any_hit), 32'h0);

        // First taken branch at 0x100, predicted not-taken
        IF_pc = 32'h100;
        ex_set(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 2'b00);
        #1;
        check("br1_status", 32'(prediction_status), 32'd0);
        check("br1_same_cycle_miss", 32'(IF_BTBhit), 32'h0);
        tick();
        ex_idle();
        #1;
        check("br1_hit", 32'(IF_BTBhit), 32'h1);
        check("br1_cnt", 32'(IF_branch_prediction), 32'h2);
        check("br1_target", IF_pc_imm, 32'h80);
        check("br1_is_branch", 32'(IF_Branch), 32'h1);
        check("br1_is_jump", 32'(IF_Jump), 32'h0);
        check("br1_branch_cnt", 32'(branch_cnt), 32'd1);
        check("br1_mispredict_cnt", 32'(mispredict_cnt), 32'd1);

        // Saturating counter: four taken then five not-taken
        for (int i = 0; i < 9; i++) begin
            ex_set(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, tk_seq[i], pred_seq[i]);
            #1;
            check("sat_status", 32'(prediction_status), 32'(stat_exp[i]));
            tick();
            ex_idle();
            #1;
            check("sat_cnt", 32'(IF_branch_prediction), 32'(cnt_exp[i]));
        end
        check("sat_branch_cnt", 32'(branch_cnt), 32'd10);
        check("sat_mispredict_cnt", 32'(mispredict_cnt), 32'd3);

        // JAL at 0x100 overwrites, then aliasing branch at 0x200 evicts it
        ex_set(1'b0, 1'b1, 1'b0, 32'h100, 32'h500, 1'b0, 2'b00);
        #1;
        check("jal_status", 32'(prediction_status), 32'd3);
        tick();
        ex_idle();
        #1;
        check("jal_hit", 32'(IF_BTBhit), 32'h1);
        check("jal_cnt", 32'(IF_branch_prediction), 32'h3);
        check("jal_is_jump", 32'(IF_Jump), 32'h1);
        check("jal_is_branch", 32'(IF_Branch), 32'h0);
        check("jal_target", IF_pc_imm, 32'h500);
        ex_set(1'b1, 1'b0, 1'b0, 32'h200, 32'h300, 1'b1, 2'b00);
        tick();
        ex_idle();
        #1;
        check("alias_old_miss", 32'(IF_BTBhit), 32'h0);
        IF_pc = 32'h200;
        #1;
        check("alias_new_hit", 32'(IF_BTBhit), 32'h1);
        check("alias_new_cnt", 32'(IF_branch_prediction), 32'h2);
        check("alias_new_target", IF_pc_imm, 32'h300);
        check("alias_new_is_jump", 32'(IF_Jump), 32'h0);
        check("alias_branch_cnt", 32'(branch_cnt), 32'd11);
        check("alias_mispredict_cnt", 32'(mispredict_cnt), 32'd4);

        // JALR hitting 0x200 invalidates; same-cycle lookup still sees old entry
        ex_set(1'b0, 1'b1, 1'b1, 32'h200, 32'h999, 1'b0, 2'b00);
        #1;
        check("jalr_same_cycle_hit", 32'(IF_BTBhit), 32'h1);
        tick();
        ex_idle();
        #1;
        check("jalr_after_miss", 32'(IF_BTBhit), 32'h0);

        // Flush with a concurrent JAL update at 0x200
        ex_set(1'b0, 1'b1, 1'b0, 32'h300, 32'h700, 1'b0, 2'b00);
        tick();
        ex_idle();
        IF_pc = 32'h300;
        #1;
        check("pre_flush_hit", 32'(IF_BTBhit), 32'h1);
        flush_req = 1'b1;
        ex_set(1'b0, 1'b1, 1'b0, 32'h200, 32'h600, 1'b0, 2'b00);
        tick();
        flush_req = 1'b0;
        ex_idle();
        #1;
        check("flush_init_done", 32'(init_done), 32'h0);
        check("flush_forced_miss", 32'(IF_BTBhit), 32'h0);
        check("flush_forced_imm", IF_pc_imm, 32'h0);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) check("resweep_63_not_done", 32'(init_done), 32'h0);
        end
        check("resweep_64_done", 32'(init_done), 32'h1);
        check("post_flush_300_miss", 32'(IF_BTBhit), 32'h0);
        IF_pc = 32'h200;
        #1;
        check("post_flush_200_miss", 32'(IF_BTBhit), 32'h0);
        IF_pc = 32'h100;
        #1;
        check("post_flush_100_miss", 32'(IF_BTBhit), 32'h0);
        check("flush_keeps_branch_cnt", 32'(branch_cnt), 32'd11);
        check("flush_keeps_mispredict_cnt", 32'(mispredict_cnt), 32'd4);

        // Mispredict counter wrap: 4092 more mispredicts from 4 reach 4096 == 0
        ex_set(1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000, 1'b1, 2'b00);
        #1;
        check("wrap_status", 32'(prediction_status), 32'd0);
        repeat (4091) tick();
        check("wrap_pre_max", 32'(mispredict_cnt), 32'd4095);
        tick();
        check("wrap_mispredict_zero", 32'(mispredict_cnt), 32'd0);
        check("wrap_branch_cnt", 32'(branch_cnt), 32'd7);
        ex_set(1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000, 1'b1, 2'b10);
        #1;
        check("wrap_correct_status", 32'(prediction_status), 32'd2);
        tick();
        ex_idle();
        #1;
        check("indep_branch_cnt", 32'(branch_cnt), 32'd8);
        check("indep_mispredict_cnt", 32'(mispredict_cnt), 32'd0);

        // Asynchronous reset aborts immediately
        rst_n = 1'b0;
        #1;
        check("async_rst_init_done", 32'(init_done), 32'h0);
        check("async_rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("async_rst_hit", 32'(IF_BTBhit), 32'h0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
